eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Schedules the single shared Ethernet transmitter between three frame sources: ARP replies to peers, ARP requests that resolve the target IP, and host data frames.
- Consumes the ARP event outputs of eth_recv (operation, sender MAC/IP) and keeps a one-entry ARP cache for the target.
- Sits between eth_recv and the frame builder/transmitter. Tells the transmitter what frame to build and to which destination, and grants the data source when its frame is on the wire.

Parameters:
- RETRY_CYCLES, 25000000: clk cycles between ARP requests while the target is unresolved.
- GAP_CYCLES, 4: idle cycles forced after every frame before the next grant (minimum 1).
- WDOG_CYCLES, 65535: transmit watchdog limit in cycles. Only used when ETH_TX_WDOG_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- i_self_mac  in  48  own MAC (static)
- i_self_ip  in  32  own IP (static)
- i_target_ip  in  32  IP to resolve and send data to
- i_arp_op  in  2  from eth_recv, one-cycle: 01 = request to us, 02 = reply, 00 = none
- i_arp_mac  in  48  sender MAC, valid with i_arp_op
- i_arp_ip  in  32  sender IP, valid with i_arp_op
- i_data_req  in  1  data source has a frame ready (level)
- o_data_gnt  out  1  data frame is being transmitted
- o_tx_start  out  1  one-cycle start pulse to the transmitter
- o_tx_kind  out  2  0 = none, 1 = ARP reply, 2 = ARP request, 3 = data; held from START through WAIT
- o_tx_dst_mac  out  48  destination MAC, held with o_tx_kind
- o_tx_dst_ip  out  32  destination IP, held with o_tx_kind
- i_tx_done  in  1  one-cycle pulse from the transmitter at end of frame
- o_target_mac  out  48  cached target MAC
- o_target_vld  out  1  cache valid
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, the cache is invalid, all pending flags are 0 and the retry counter is 0.
- ARP cache:
  - When i_arp_op==02 and i_arp_ip==i_target_ip, latch i_arp_mac into o_target_mac and set o_target_vld the next cycle.
  - A change of i_target_ip (compared against a registered copy) clears o_target_vld the next cycle. That clear wins over a same-cycle reply.
- Reply pending:
  - i_arp_op==01 sets rpl_pend and latches i_arp_mac/i_arp_ip.
  - A newer request overwrites the latched MAC/IP while the reply has not yet reached START.
  - A request that arrives during an ARP-reply frame re-arms rpl_pend for a second reply.
- Request pending:
  - While o_target_vld==0 the retry counter decrements when non-zero.
  - At 0 it sets req_pend and reloads to RETRY_CYCLES-1. The first request is therefore raised right after reset release.
  - While o_target_vld==1 the counter holds 0 and req_pend is cleared.
- Priority, evaluated in IDLE: rpl_pend > req_pend > (i_data_req and o_target_vld). Data is never granted while the cache is invalid.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE → START when any source qualifies. The chosen source's pending flag is cleared and o_tx_kind and the destination are registered.
  - START lasts 1 cycle with o_tx_start=1, then → WAIT.
  - WAIT → GAP on i_tx_done. i_tx_done is sampled only in WAIT and ignored in the other states.
  - GAP counts GAP_CYCLES cycles, clears o_tx_kind to 0, then → IDLE.
- Destinations by kind:
  - Reply: latched requester MAC/IP.
  - Request: 48'hFFFFFFFFFFFF and i_target_ip.
  - Data: o_target_mac and i_target_ip.
- o_data_gnt is 1 in START and WAIT when o_tx_kind==3, and 0 otherwise.
- Invalidating the cache mid data frame does not abort the frame. The frame completes normally.
- Scheduling latency: a request to us seen in IDLE produces o_tx_start 2 cycles after the i_arp_op pulse (flag set, then IDLE→START).

Optional Feature:
- Macro ETH_TX_WDOG_EN.
- Defined:
  - A counter runs in WAIT. If WDOG_CYCLES cycles pass without i_tx_done, the FSM goes to GAP.
  - An ARP reply or ARP request that was cut off this way re-sets its pending flag. A data frame that was cut off is dropped.
- Not defined: WAIT holds until i_tx_done with no limit.

Test Plan:
- Reset release with target unresolved → o_tx_start within 2 cycles, kind=2, dst_mac=FFFFFFFFFFFF, dst_ip=i_target_ip. With no reply, the next request follows RETRY_CYCLES after the previous one.
- i_arp_op=02 with i_arp_ip==i_target_ip and MAC 00:11:22:33:44:55 → o_target_vld=1 and o_target_mac=001122334455 next cycle. ARP requests stop.
- i_arp_op=01 and i_data_req=1 in the same cycle with the cache valid → reply (kind=1, dst = sender) first; after i_tx_done + GAP_CYCLES, data (kind=3) with o_data_gnt=1 until i_tx_done.
- i_data_req=1 held with the cache invalid → o_data_gnt stays 0 and only kind-2 frames are issued. After a matching reply, data is granted.
- i_target_ip changes during a data frame → the frame completes on i_tx_done, o_target_vld drops, and the next frame is an ARP request.
- With ETH_TX_WDOG_EN and WDOG_CYCLES=100: start an ARP reply and withhold i_tx_done → return to GAP after 100 cycles and the reply is reissued. Without the macro, o_busy stays 1 indefinitely.

Source files
------------

// File: rtl/eth_tx_sched.sv
// Arbitrates the shared Ethernet transmitter between ARP replies, ARP requests and host data.
// Optional transmit watchdog: define ETH_TX_WDOG_EN to bound the WAIT state by WDOG_CYCLES.
module eth_tx_sched #(
   parameter int RETRY_CYCLES = 25000000,
   parameter int GAP_CYCLES   = 4,
   parameter int WDOG_CYCLES  = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] i_self_mac,
   input  logic [31:0] i_self_ip,
   input  logic [31:0] i_target_ip,
   input  logic [1:0]  i_arp_op,
   input  logic [47:0] i_arp_mac,
   input  logic [31:0] i_arp_ip,
   input  logic        i_data_req,
   output logic        o_data_gnt,
   output logic        o_tx_start,
   output logic [1:0]  o_tx_kind,
   output logic [47:0] o_tx_dst_mac,
   output logic [31:0] o_tx_dst_ip,
   input  logic        i_tx_done,
   output logic [47:0] o_target_mac,
   output logic        o_target_vld,
   output logic        o_busy
);

   localparam int RW = $clog2(RETRY_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [1:0] OP_REQ = 2'd1;
   localparam logic [1:0] OP_RPL = 2'd2;

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_RPL  = 2'd1;
   localparam logic [1:0] K_REQ  = 2'd2;
   localparam logic [1:0] K_DATA = 2'd3;

   typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

   state_t        state;
   logic [GW-1:0] gap_cnt;
   logic [RW-1:0] retry_cnt;
   logic          req_pend;
   logic          rpl_pend;
   logic [47:0]   rpl_mac;
   logic [31:0]   rpl_ip;
   logic [31:0]   target_ip_q;
   logic          ip_chg;
   logic [1:0]    sel_kind;
   logic          wdog_cut;
   logic          unused_cfg;

   assign ip_chg = (i_target_ip != target_ip_q);

   // Own MAC/IP belong to the frame builder; they are not needed for scheduling.
`ifdef ETH_TX_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   assign wdog_cut   = (state == WAIT) && !i_tx_done && (wdog_cnt == WW'(WDOG_CYCLES - 1));
   assign unused_cfg = ^{i_self_mac, i_self_ip};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdog_cnt <= '0;
      else if (state != WAIT)
         wdog_cnt <= '0;
      else if (!wdog_cut)
         wdog_cnt <= wdog_cnt + 1'b1;
   end
`else
   assign wdog_cut   = 1'b0;
   assign unused_cfg = ^{i_self_mac, i_self_ip} ^ (WDOG_CYCLES == 0);
`endif

   // A request arriving this cycle defers selection so its reply outranks data/requests.
   always_comb begin
      sel_kind = K_NONE;
      if (state == IDLE && i_arp_op != OP_REQ) begin
         if (rpl_pend)
            sel_kind = K_RPL;
         else if (req_pend)
            sel_kind = K_REQ;
         else if (i_data_req && o_target_vld)
            sel_kind = K_DATA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_ip_q  <= '0;
         o_target_vld <= 1'b0;
         o_target_mac <= '0;
      end else begin
         target_ip_q <= i_target_ip;
         if (ip_chg)
            o_target_vld <= 1'b0;
         else if (i_arp_op == OP_RPL && i_arp_ip == i_target_ip) begin
            o_target_mac <= i_arp_mac;
            o_target_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpl_pend <= 1'b0;
         rpl_mac  <= '0;
         rpl_ip   <= '0;
      end else if (i_arp_op == OP_REQ) begin
         rpl_pend <= 1'b1;
         rpl_mac  <= i_arp_mac;
         rpl_ip   <= i_arp_ip;
      end else if (wdog_cut && o_tx_kind == K_RPL)
         rpl_pend <= 1'b1;
      else if (sel_kind == K_RPL)
         rpl_pend <= 1'b0;
   end

   // A new retry expiry wins over the IDLE clear of the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt <= '0;
         req_pend  <= 1'b0;
      end else if (o_target_vld) begin
         retry_cnt <= '0;
         req_pend  <= 1'b0;
      end else if (retry_cnt == '0) begin
         retry_cnt <= RW'(RETRY_CYCLES - 1);
         req_pend  <= 1'b1;
      end else begin
         retry_cnt <= retry_cnt - 1'b1;
         if (wdog_cut && o_tx_kind == K_REQ)
            req_pend <= 1'b1;
         else if (sel_kind == K_REQ)
            req_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         gap_cnt      <= '0;
         o_tx_start   <= 1'b0;
         o_tx_kind    <= K_NONE;
         o_tx_dst_mac <= '0;
         o_tx_dst_ip  <= '0;
         o_data_gnt   <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_kind != K_NONE) begin
                  state      <= START;
                  o_tx_start <= 1'b1;
                  o_busy     <= 1'b1;
                  o_tx_kind  <= sel_kind;
                  o_data_gnt <= (sel_kind == K_DATA);
                  if (sel_kind == K_RPL) begin
                     o_tx_dst_mac <= rpl_mac;
                     o_tx_dst_ip  <= rpl_ip;
                  end else if (sel_kind == K_REQ) begin
                     o_tx_dst_mac <= 48'hFFFF_FFFF_FFFF;
                     o_tx_dst_ip  <= i_target_ip;
                  end else begin
                     o_tx_dst_mac <= o_target_mac;
                     o_tx_dst_ip  <= i_target_ip;
                  end
               end
            end
            START: begin
               state      <= WAIT;
               o_tx_start <= 1'b0;
            end
            WAIT: begin
               if (i_tx_done || wdog_cut) begin
                  state        <= GAP;
                  gap_cnt      <= GW'(GAP_CYCLES - 1);
                  o_tx_kind    <= K_NONE;
                  o_tx_dst_mac <= '0;
                  o_tx_dst_ip  <= '0;
                  o_data_gnt   <= 1'b0;
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
